generator_apasare: RTL and testbench
====================================

GENERATOR_APASARE -- requirements
Module: generator_apasare

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 1_485_000, is the number of consecutive stable cycles needed to accept a level change (10 ms at 148.5 MHz).
REQ-002 Parameter REPEAT_DELAY_CYC, default 74_250_000, is the number of held cycles after the first pulse before auto-repeat starts (0.5 s).
REQ-003 Parameter REPEAT_PERIOD_CYC, default 14_850_000, is the interval between auto-repeat pulses (100 ms).
REQ-004 Port clk_148Mhz, input, 1 bit: the single clock; every flop in the block is clocked on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Ports btnL, btnR, btnU and btnD, inputs, 1 bit each: raw, asynchronous, bouncing board buttons; 1 means pressed.
REQ-007 Ports buton_apasatL, buton_apasatR, buton_apasatU and buton_apasatD, outputs, 1 bit each, registered: one-cycle move-request pulses for the position controller.

Function
REQ-008 Each button channel SHALL synchronize its raw input through two flops to produce level s; no other logic SHALL use the raw input.
REQ-009 Each channel SHALL run an FSM with the states IDLE, DEB_PRESS, HELD, REPEAT and DEB_REL, plus one 28-bit counter cnt.
REQ-010 IDLE: when s=1, go to DEB_PRESS with cnt=0.
REQ-011 DEB_PRESS: when s=0, go to IDLE; when s=1 and cnt=DEBOUNCE_CYC-1, go to HELD with cnt=0 and raise a pulse; otherwise increment cnt.
REQ-012 HELD: when s=0, go to DEB_REL with cnt=0; when cnt=REPEAT_DELAY_CYC-1, go to REPEAT with cnt=0 and raise a pulse; otherwise increment cnt.
REQ-013 REPEAT: when s=0, go to DEB_REL with cnt=0; when cnt=REPEAT_PERIOD_CYC-1, raise a pulse and set cnt=0; otherwise increment cnt.
REQ-014 DEB_REL: when s=1, set cnt=0 and stay in DEB_REL; when s=0 and cnt=DEBOUNCE_CYC-1, go to IDLE; otherwise increment cnt; no pulses are raised in this state.
REQ-015 A channel pulse SHALL be high for exactly one cycle, registered on the edge that takes the transition.
REQ-016 First-pulse latency SHALL be exactly DEBOUNCE_CYC+2 rising edges, counted from the first edge that samples the raw input high.
REQ-017 When two opposing channels (L/R or U/D) pulse on the same cycle, both outputs of that pair SHALL stay 0 for that cycle.
REQ-018 Orthogonal channels (for example L and U) SHALL pulse independently and may coincide.
REQ-019 A bounce shorter than DEBOUNCE_CYC cycles SHALL produce no pulse and no state change beyond a DEB_PRESS/IDLE or DEB_REL counter restart.
REQ-020 The cnt width (28 bits) SHALL cover every parameter value up to 2^28-1; a parameter value of 0 is illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-021 While reset=1, all synchronizer flops, all cnt registers and all outputs SHALL be 0, and every FSM SHALL be in IDLE, independent of the clock.
REQ-022 A reset asserted in the middle of a press SHALL abort the press; after reset is released, a still-held button SHALL need a full DEBOUNCE_CYC+2 cycles before its next pulse.

Structure
REQ-023 The FSM state encoding and the default parameter values SHALL live in a shared include/package used by the design and the bench.
REQ-024 One channel SHALL be a sub-module named buton_canal (synchronizer, FSM, counter, pulse flop), instantiated four times; the top SHALL contain only the opposing-pair suppression and the output registers.

Verification (DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=20, REPEAT_PERIOD_CYC=8)
REQ-025 btnL held high from edge 0 -> buton_apasatL is high for exactly one cycle at edge 6, then at edges 26, 34, 42 and so on; no other output toggles.
REQ-026 btnR toggles 1,0,1,0 on every edge for 10 cycles, then stays 0 -> no pulse is ever produced.
REQ-027 btnL and btnR both raised on edge 0 -> both outputs stay 0 for the whole hold; btnU and btnD raised on edge 0 -> the same result for that pair.
REQ-028 btnU raised on edge 0 and released after edge 10 -> one pulse only; a re-press 2 cycles after the release gives no new pulse until the release has been debounced and a fresh DEBOUNCE_CYC+2 cycles have passed.
REQ-029 btnD held high and reset pulsed at edge 15 -> all outputs are 0 immediately; the next pulse appears 6 edges after reset is released.

Source files
------------

// File: rtl/generator_apasare_pkg.sv
// Shared definitions for the button pulse generator: channel FSM states,
// counter width and the default timing values at 148.5 MHz.
package generator_apasare_pkg;

  localparam int unsigned CNT_W                 = 28;
  localparam int unsigned DEBOUNCE_CYC_DEF      = 1_485_000;   // 10 ms
  localparam int unsigned REPEAT_DELAY_CYC_DEF  = 74_250_000;  // 0.5 s
  localparam int unsigned REPEAT_PERIOD_CYC_DEF = 14_850_000;  // 100 ms

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_HELD      = 3'd2,
    ST_REPEAT    = 3'd3,
    ST_DEB_REL   = 3'd4
  } stare_t;

endpackage

// File: rtl/buton_canal.sv
// One button channel: 2-flop synchronizer, debounce / auto-repeat FSM,
// 28-bit cycle counter and a one-cycle pulse flop.
module buton_canal
  import generator_apasare_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC      = DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DELAY_CYC  = REPEAT_DELAY_CYC_DEF,
  parameter int unsigned REPEAT_PERIOD_CYC = REPEAT_PERIOD_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic puls_next,
  output logic puls
);

  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  if (DEBOUNCE_CYC == 0 || DEBOUNCE_CYC > CNT_MAX ||
      REPEAT_DELAY_CYC == 0 || REPEAT_DELAY_CYC > CNT_MAX ||
      REPEAT_PERIOD_CYC == 0 || REPEAT_PERIOD_CYC > CNT_MAX) begin : g_param_err
    $error("buton_canal: timing parameters must be in 1 .. 2^28-1");
  end

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD_CYC - 1);

  logic [1:0]       sync_q, sync_d;
  stare_t           stare_q, stare_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             puls_q, puls_d;
  logic             s;

  assign s = sync_q[1];

  // Next-state, counter and pulse decode; the raw input only enters sync_d.
  always_comb begin
    sync_d  = {sync_q[0], btn};
    stare_d = stare_q;
    cnt_d   = cnt_q + CNT_W'(1);
    puls_d  = 1'b0;
    case (stare_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (s) stare_d = ST_DEB_PRESS;
      end
      ST_DEB_PRESS: begin
        if (!s) begin
          stare_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          stare_d = ST_HELD;
          cnt_d   = '0;
          puls_d  = 1'b1;
        end
      end
      ST_HELD: begin
        if (!s) begin
          stare_d = ST_DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == DLY_LAST) begin
          stare_d = ST_REPEAT;
          cnt_d   = '0;
          puls_d  = 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!s) begin
          stare_d = ST_DEB_REL;
          cnt_d   = '0;
        end else if (cnt_q == PER_LAST) begin
          cnt_d   = '0;
          puls_d  = 1'b1;
        end
      end
      ST_DEB_REL: begin
        if (s) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          stare_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        stare_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Channel state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      stare_q <= ST_IDLE;
      cnt_q   <= '0;
      puls_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      stare_q <= stare_d;
      cnt_q   <= cnt_d;
      puls_q  <= puls_d;
    end
  end

  // The decoded pulse is also exported so the top can apply pair
  // suppression and register its outputs on the same edge as puls_q.
  assign puls_next = puls_d;
  assign puls      = puls_q;

endmodule

// File: rtl/generator_apasare.sv
// Four debounced, auto-repeating button channels feeding registered
// one-cycle move requests; opposing pulses on the same cycle cancel.
module generator_apasare
  import generator_apasare_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC      = DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DELAY_CYC  = REPEAT_DELAY_CYC_DEF,
  parameter int unsigned REPEAT_PERIOD_CYC = REPEAT_PERIOD_CYC_DEF
) (
  input  logic clk_148Mhz,
  input  logic reset,
  input  logic btnL,
  input  logic btnR,
  input  logic btnU,
  input  logic btnD,
  output logic buton_apasatL,
  output logic buton_apasatR,
  output logic buton_apasatU,
  output logic buton_apasatD
);

  logic [3:0] btn_raw;
  logic [3:0] puls_next;
  logic [3:0] puls;
  logic [3:0] out_q, out_d;

  assign btn_raw = {btnL, btnR, btnU, btnD};

  for (genvar i = 0; i < 4; i++) begin : g_canal
    buton_canal #(
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_PERIOD_CYC(REPEAT_PERIOD_CYC)
    ) u_canal (
      .clk      (clk_148Mhz),
      .rst      (reset),
      .btn      (btn_raw[i]),
      .puls_next(puls_next[i]),
      .puls     (puls[i])
    );
  end

  // Opposing-pair suppression: bit order is L, R, U, D.
  always_comb begin
    out_d    = '0;
    out_d[3] = puls_next[3] & ~puls_next[2];
    out_d[2] = puls_next[2] & ~puls_next[3];
    out_d[1] = puls_next[1] & ~puls_next[0];
    out_d[0] = puls_next[0] & ~puls_next[1];
  end

  // Output registers.
  always_ff @(posedge clk_148Mhz or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= out_d;
  end

  assign buton_apasatL = out_q[3];
  assign buton_apasatR = out_q[2];
  assign buton_apasatU = out_q[1];
  assign buton_apasatD = out_q[0];

  // A registered request can only exist where its channel pulsed.
  a_out_from_canal: assert property (@(posedge clk_148Mhz) disable iff (reset)
    (out_q & ~puls) == 4'b0000);

endmodule

// File: tb/tb_generator_apasare.sv
// Directed bench for generator_apasare with short timing parameters.
module tb_generator_apasare;
  import generator_apasare_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned DLY = 20;
  localparam int unsigned PER = 8;

  logic clk_148Mhz;
  logic reset;
  logic btnL, btnR, btnU, btnD;
  logic buton_apasatL, buton_apasatR, buton_apasatU, buton_apasatD;
  logic [3:0] outs;

  int n_checks = 0;
  int n_errors = 0;

  generator_apasare #(
    .DEBOUNCE_CYC     (DEB),
    .REPEAT_DELAY_CYC (DLY),
    .REPEAT_PERIOD_CYC(PER)
  ) dut (
    .clk_148Mhz   (clk_148Mhz),
    .reset        (reset),
    .btnL         (btnL),
    .btnR         (btnR),
    .btnU         (btnU),
    .btnD         (btnD),
    .buton_apasatL(buton_apasatL),
    .buton_apasatR(buton_apasatR),
    .buton_apasatU(buton_apasatU),
    .buton_apasatD(buton_apasatD)
  );

  assign outs = {buton_apasatL, buton_apasatR, buton_apasatU, buton_apasatD};

  initial clk_148Mhz = 1'b0;
  always #5 clk_148Mhz = ~clk_148Mhz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle before sampling.
  task automatic step();
    @(posedge clk_148Mhz);
    #1;
  endtask

  // Expected pulse on edge e for a hold starting at edge 0.
  function automatic bit pulse_at(input int e, input bit repeat_on);
    int first;
    first = int'(DEB) + 2;
    if (e == first) return 1'b1;
    if (repeat_on && e >= first + int'(DLY) && ((e - first - int'(DLY)) % int'(PER)) == 0)
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset(input string tag);
    reset = 1'b1;
    btnL = 1'b0; btnR = 1'b0; btnU = 1'b0; btnD = 1'b0;
    #1;
    check({tag, " outs"}, 32'(outs), 32'h0);
    check({tag, " st L"}, 32'(dut.g_canal[3].u_canal.stare_q), 32'(ST_IDLE));
    check({tag, " st R"}, 32'(dut.g_canal[2].u_canal.stare_q), 32'(ST_IDLE));
    check({tag, " st U"}, 32'(dut.g_canal[1].u_canal.stare_q), 32'(ST_IDLE));
    check({tag, " st D"}, 32'(dut.g_canal[0].u_canal.stare_q), 32'(ST_IDLE));
    check({tag, " cnt L"}, 32'(dut.g_canal[3].u_canal.cnt_q), 32'h0);
    check({tag, " cnt D"}, 32'(dut.g_canal[0].u_canal.cnt_q), 32'h0);
    check({tag, " sync U"}, 32'(dut.g_canal[1].u_canal.sync_q), 32'h0);
    step();
    step();
    check({tag, " outs held"}, 32'(outs), 32'h0);
    reset = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset = 1'b1;
    btnL = 1'b0; btnR = 1'b0; btnU = 1'b0; btnD = 1'b0;

    do_reset("init");

    // L held: first pulse at 6, then 26, 34, 42, 50
    btnL = 1'b1;
    for (int e = 0; e <= 50; e++) begin
      step();
      check($sformatf("L hold e%0d", e), 32'(outs), pulse_at(e, 1'b1) ? 32'h8 : 32'h0);
    end
    btnL = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      check($sformatf("L release e%0d", e), 32'(outs), 32'h0);
    end
    do_reset("r1");

    // R bouncing every edge: never a pulse
    for (int e = 0; e < 30; e++) begin
      btnR = (e < 10) ? ((e % 2) == 0) : 1'b0;
      step();
      check($sformatf("R bounce e%0d", e), 32'(outs), 32'h0);
    end
    do_reset("r2");

    // Opposing pairs held together: fully suppressed
    btnL = 1'b1; btnR = 1'b1;
    for (int e = 0; e < 44; e++) begin
      step();
      check($sformatf("LR pair e%0d", e), 32'(outs), 32'h0);
    end
    do_reset("r3");
    btnU = 1'b1; btnD = 1'b1;
    for (int e = 0; e < 44; e++) begin
      step();
      check($sformatf("UD pair e%0d", e), 32'(outs), 32'h0);
    end
    do_reset("r4");

    // Orthogonal L+U pulse together
    btnL = 1'b1; btnU = 1'b1;
    for (int e = 0; e <= 42; e++) begin
      step();
      check($sformatf("LU ortho e%0d", e), 32'(outs), pulse_at(e, 1'b1) ? 32'hA : 32'h0);
    end
    do_reset("r5");

    // U: 4-edge press is too short, 5-edge press just makes it
    for (int e = 0; e < 16; e++) begin
      btnU = (e < 4);
      step();
      check($sformatf("U short e%0d", e), 32'(outs), 32'h0);
    end
    for (int e = 0; e < 16; e++) begin
      btnU = (e < 5);
      step();
      check($sformatf("U min e%0d", e), 32'(outs), (e == 6) ? 32'h2 : 32'h0);
    end

    // U: release after 10, re-press at 13 stalls in release debounce,
    // release at 31, fresh press at 40 pulses at 46
    for (int e = 0; e <= 48; e++) begin
      btnU = (e <= 10) || (e >= 13 && e <= 30) || (e >= 40);
      step();
      check($sformatf("U repress e%0d", e), 32'(outs), (e == 6 || e == 46) ? 32'h2 : 32'h0);
    end
    do_reset("r6");

    // D held, reset pulsed at 15, then an async reset on a live pulse
    btnD = 1'b1;
    for (int e = 0; e <= 14; e++) begin
      step();
      check($sformatf("D hold e%0d", e), 32'(outs), (e == 6) ? 32'h1 : 32'h0);
    end
    reset = 1'b1;
    #1;
    check("D rst immediate", 32'(outs), 32'h0);
    step();
    check("D rst e15", 32'(outs), 32'h0);
    check("D rst cnt", 32'(dut.g_canal[0].u_canal.cnt_q), 32'h0);
    reset = 1'b0;
    for (int e = 16; e <= 22; e++) begin
      step();
      check($sformatf("D after rst e%0d", e), 32'(outs), (e == 22) ? 32'h1 : 32'h0);
    end
    reset = 1'b1;
    #1;
    check("D async clear", 32'(outs), 32'h0);
    step();
    check("D rst e23", 32'(outs), 32'h0);
    reset = 1'b0;
    for (int e = 24; e <= 32; e++) begin
      step();
      check($sformatf("D after rst2 e%0d", e), 32'(outs), (e == 30) ? 32'h1 : 32'h0);
    end
    do_reset("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
